adc_pipe_align_encoder: RTL and testbench
=========================================

Name: adc_pipe_align_encoder

Overview:
Single-clock successor to the DDR pipeline-ADC encoder. It time-aligns per-stage codes that arrive skewed by one clock per stage and applies the redundancy-weighted sum with saturation. A selectable block-averaging mode is included. It sits between the analog pipeline stage comparators and the chip-level data output / SPI readout.

Parameters:
NUM_BITS, 3, output resolution
NUM_STAGES, 2, redundant pipeline stages before the final flash stage
NUM_BITS_PER_STAGE, 2, code bits per pipeline stage
REDUNDANCY, 1, redundant bits per stage
BITS_ADC_STAGE, 1, final flash-stage bits
AVG_LOG2, 2, averaging window of 2^AVG_LOG2 samples (>=1)

Ports:
clk_i  in  1  single system clock, rising edge
reset_i  in  1  asynchronous, active-high reset
mode_i  in  1  0 = raw conversion, 1 = block average
sample_valid_i  in  1  stage-0 code of a new sample present this cycle
d_stage_i  in  NUM_STAGES*NUM_BITS_PER_STAGE  stage k code in slice [k*B +: B], B = NUM_BITS_PER_STAGE
d_last_stage_i  in  BITS_ADC_STAGE  final-stage code
d_o  out  NUM_BITS  corrected (or averaged) output word
d_valid_o  out  1  one-cycle strobe, d_o valid
ovf_o  out  1  saturation occurred in the word on d_o, qualified by d_valid_o

Behaviour:
- Arrival skew: sample s has stage 0 at cycle t (sample_valid_i=1), stage k at t+k, last stage at t+NUM_STAGES.
- Alignment: stage k code passes through NUM_STAGES-k registers. Last-stage code is unregistered. All codes are aligned at cycle t+NUM_STAGES.
- Valid pipeline: sample_valid_i is delayed NUM_STAGES cycles. It qualifies the sum register enable. Codes on non-valid slots are ignored.
- Weight: stage k code is shifted left by (NUM_STAGES-1-k)*(B-REDUNDANCY) + BITS_ADC_STAGE - REDUNDANCY. The last-stage code is unshifted. Codes are treated as unsigned, including the illegal code 2^B-1.
- Sum is computed NUM_BITS+1 bits wide. If sum > 2^NUM_BITS-1, the result is clamped to all-ones and the ovf flag is set.
- Raw mode: sum register loads at edge t+NUM_STAGES+1. d_o and ovf_o are updated and d_valid_o pulses that cycle. Latency is NUM_STAGES+1 cycles from sample_valid_i.
- Average mode: the accumulator (NUM_BITS+AVG_LOG2 bits) and the sample counter advance on each valid clamped result.
  - On the 2^AVG_LOG2-th result, d_o = (acc + result) >> AVG_LOG2, truncated. d_valid_o pulses one cycle after that result. ovf_o = OR of the window's clamp flags.
  - acc, counter and the ovf OR are then cleared in the same edge.
- Throughput: back-to-back valid every cycle is supported. Gaps of any length are allowed, and the alignment delay holds no state beyond the fixed shift registers.
- Mode change: mode_i is registered internally (mode_q). Any cycle where mode_i != mode_q clears acc, counter and ovf OR. Samples in flight are not dropped and emerge in the new mode. A result in the same cycle as the change is treated under the new mode and starts a fresh window.
- Reset (async assert, sync-safe release) clears all delay registers, the valid pipeline, acc, counter and mode_q (0). Samples in flight are lost.
- Reset values: d_o=0, d_valid_o=0, ovf_o=0.
- d_o and ovf_o hold their value between strobes.

Decomposition:
- Package adc_pipe_pkg:
  - function num_stages(NUM_BITS, B, R, BL)
  - function stage_shift(k, N, B, R, BL)
  - localparam MODE_RAW=1'b0, MODE_AVG=1'b1
  - Also reused by the existing DDR encoder.
- Sub-module adc_pipe_delay_line: parametrised WIDTH/DEPTH shift register with async reset. DEPTH=0 is a pass-through. One instance per stage plus one for valid.
- Top keeps the weighting/clamp and the averaging FSM (counter + accumulator).

Test Plan:
- Reset, single raw sample: d0=2 at t, d1=2 at t+1, last=1 at t+2 -> d_o=7, ovf_o=0, d_valid_o pulse at t+3 only.
- Raw overflow: d0=3, d1=2, last=1 (sum 9) -> d_o=7, ovf_o=1. Next sample d0=1, d1=1, last=0 -> d_o=3, ovf_o=0.
- Back-to-back streaming, 8 consecutive valid samples with distinct codes, some with gaps -> 8 strobes in order, each NUM_STAGES+1 cycles after its input. No cross-stage mixing.
- Average mode, 4 results of 7, 6, 5, 3 -> single strobe d_o=5 (21>>2), ovf_o=0. A window containing one clamped sample gives ovf_o=1.
- Mode toggle mid-window after 2 results -> those 2 are discarded. Next 4 results form the output window, and raw strobes stop immediately.
- reset_i asserted asynchronously between clock edges with 2 samples in flight -> outputs go to 0 at once, no strobe after release, and the next sample decodes correctly.

Source files
------------

// File: rtl/adc_pipe_pkg.sv
// Shared constants and weighting helpers for the pipeline-ADC encoders
// (single-clock aligner and the DDR encoder).
package adc_pipe_pkg;

  localparam logic MODE_RAW = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // Redundant stages needed for a given output resolution.
  function automatic int num_stages(input int num_bits, input int b,
                                    input int r, input int bl);
    return (num_bits - bl) / (b - r);
  endfunction

  // Left shift applied to stage k's code before summation.
  function automatic int stage_shift(input int k, input int n, input int b,
                                     input int r, input int bl);
    return (n - 1 - k) * (b - r) + bl - r;
  endfunction

endpackage

// File: rtl/adc_pipe_delay_line.sv
// Fixed-depth shift register with async reset; DEPTH=0 degenerates to a wire.
module adc_pipe_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_shift
      logic [WIDTH-1:0] sr [DEPTH];

      // NOTE: every tap is reset so a reset really discards samples in flight;
      // an unreset delay line would leak stale codes after release.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
          // NOTE: non-blocking assignments make every tap sample the old value
          // of its neighbour, giving a true shift rather than a fall-through.
          sr[0] <= d;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
      end

      assign q = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/adc_pipe_align_encoder.sv
// Aligns skewed per-stage ADC codes, forms the redundancy-weighted clamped sum,
// and optionally block-averages 2^AVG_LOG2 results.
module adc_pipe_align_encoder
  import adc_pipe_pkg::*;
#(
  parameter int NUM_BITS           = 3,
  parameter int NUM_STAGES         = 2,
  parameter int NUM_BITS_PER_STAGE = 2,
  parameter int REDUNDANCY         = 1,
  parameter int BITS_ADC_STAGE     = 1,
  parameter int AVG_LOG2           = 2
) (
  input  logic                                     clk_i,
  input  logic                                     reset_i,
  input  logic                                     mode_i,
  input  logic                                     sample_valid_i,
  input  logic [NUM_STAGES*NUM_BITS_PER_STAGE-1:0] d_stage_i,
  input  logic [BITS_ADC_STAGE-1:0]                d_last_stage_i,
  output logic [NUM_BITS-1:0]                      d_o,
  output logic                                     d_valid_o,
  output logic                                     ovf_o
);

  localparam int B  = NUM_BITS_PER_STAGE;
  localparam int SW = NUM_BITS + 1;
  localparam int AW = NUM_BITS + AVG_LOG2;
  localparam logic [SW-1:0]       MAX_CODE = SW'((1 << NUM_BITS) - 1);
  localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

  logic [B-1:0] code_al [NUM_STAGES];
  logic         valid_al;

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      adc_pipe_delay_line #(.WIDTH(B), .DEPTH(NUM_STAGES - k)) u_dly (
        .clk (clk_i),
        .rst (reset_i),
        .d   (d_stage_i[k*B +: B]),
        .q   (code_al[k])
      );
    end
  endgenerate

  adc_pipe_delay_line #(.WIDTH(1), .DEPTH(NUM_STAGES)) u_valid_dly (
    .clk (clk_i),
    .rst (reset_i),
    .d   (sample_valid_i),
    .q   (valid_al)
  );

  logic [SW-1:0]       sum;
  logic                ovf_c;
  logic [NUM_BITS-1:0] res;

  always_comb begin
    // NOTE: blocking assignments here build the running sum sequentially
    // within one evaluation, which is exactly what the loop needs.
    sum = SW'(d_last_stage_i);
    for (int k = 0; k < NUM_STAGES; k++) begin
      sum = sum + (SW'(code_al[k]) << stage_shift(k, NUM_STAGES, B,
                                                  REDUNDANCY, BITS_ADC_STAGE));
    end
    ovf_c = (sum > MAX_CODE);
    res   = ovf_c ? '1 : sum[NUM_BITS-1:0];
  end

  logic                mode_q;
  logic [AVG_LOG2-1:0] cnt, cnt_n;
  logic [AW-1:0]       acc, acc_n, acc_sum;
  logic                ovf_acc, ovf_acc_n, ovf_win;
  logic [NUM_BITS-1:0] d_n;
  logic                dv_n, ovf_n;
  logic                mode_chg;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    mode_chg  = (mode_i != mode_q);
    cnt_n     = mode_chg ? '0 : cnt;
    acc_n     = mode_chg ? '0 : acc;
    ovf_acc_n = mode_chg ? 1'b0 : ovf_acc;
    acc_sum   = '0;
    ovf_win   = 1'b0;
    d_n       = d_o;
    ovf_n     = ovf_o;
    dv_n      = 1'b0;

    // A result in a mode-change cycle belongs to the new mode's fresh window.
    if (valid_al) begin
      if (mode_i == MODE_RAW) begin
        d_n   = res;
        ovf_n = ovf_c;
        dv_n  = 1'b1;
      end else begin
        acc_sum = acc_n + AW'(res);
        ovf_win = ovf_acc_n | ovf_c;
        if (cnt_n == CNT_LAST) begin
          d_n       = acc_sum[AW-1:AVG_LOG2];
          ovf_n     = ovf_win;
          dv_n      = 1'b1;
          cnt_n     = '0;
          acc_n     = '0;
          ovf_acc_n = 1'b0;
        end else begin
          cnt_n     = cnt_n + 1'b1;
          acc_n     = acc_sum;
          ovf_acc_n = ovf_win;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q    <= MODE_RAW;
      cnt       <= '0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      d_o       <= '0;
      d_valid_o <= 1'b0;
      ovf_o     <= 1'b0;
    end else begin
      mode_q    <= mode_i;
      cnt       <= cnt_n;
      acc       <= acc_n;
      ovf_acc   <= ovf_acc_n;
      d_o       <= d_n;
      d_valid_o <= dv_n;
      ovf_o     <= ovf_n;
    end
  end

endmodule

// File: tb/tb_adc_pipe_align_encoder.sv
// Self-checking bench: directed and randomized sample schedules checked against
// a sample-level reference model of alignment, weighting, clamp and averaging.
module tb_adc_pipe_align_encoder;

  localparam int NS   = 2;
  localparam int MAXC = 64;
  localparam int MAXS = 40;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       mode_i;
  logic       sample_valid_i;
  logic [3:0] d_stage_i;
  logic [0:0] d_last_stage_i;
  logic [2:0] d_o;
  logic       d_valid_o;
  logic       ovf_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  adc_pipe_align_encoder dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .mode_i         (mode_i),
    .sample_valid_i (sample_valid_i),
    .d_stage_i      (d_stage_i),
    .d_last_stage_i (d_last_stage_i),
    .d_o            (d_o),
    .d_valid_o      (d_valid_o),
    .ovf_o          (ovf_o)
  );

  // Samples of the current phase: issue cycle and the three stage codes.
  int   ns;
  int   s_t [MAXS];
  int   s_a [MAXS];
  int   s_b [MAXS];
  int   s_l [MAXS];
  logic md  [MAXC];

  // Reference state carried across phases.
  logic mode_prev;
  int   win_sum;
  int   win_n;
  logic win_ovf;
  int   hold_d;
  int   hold_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic new_phase(input logic m);
    ns = 0;
    for (int c = 0; c < MAXC; c++) md[c] = m;
  endtask

  task automatic add(input int t, input int a, input int b, input int l);
    s_t[ns] = t; s_a[ns] = a; s_b[ns] = b; s_l[ns] = l;
    ns++;
  endtask

  task automatic add_rand(input int t);
    add(t, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
        int'($urandom_range(1, 0)));
  endtask

  task automatic reset_model();
    mode_prev = 1'b0;
    win_sum = 0; win_n = 0; win_ovf = 1'b0;
    hold_d = 0; hold_o = 0;
  endtask

  // Expected strobes are derived from the sample list: a sample issued at t
  // yields its result at t+NS and its strobe one cycle later.
  task automatic run_phase(input string tag, input int n);
    int ev [MAXC];
    int ed [MAXC];
    int eo [MAXC];
    int raw, clip, ov;
    for (int c = 0; c < MAXC; c++) begin ev[c] = 0; ed[c] = 0; eo[c] = 0; end
    for (int r = 0; r < n; r++) begin
      if (md[r] != mode_prev) begin win_sum = 0; win_n = 0; win_ovf = 1'b0; end
      for (int i = 0; i < ns; i++) begin
        if (s_t[i] + NS == r) begin
          // weights: stage0 x2, stage1 x1, last stage x1
          raw  = 2 * s_a[i] + s_b[i] + s_l[i];
          ov   = (raw > 7) ? 1 : 0;
          clip = ov ? 7 : raw;
          if (md[r] == 1'b0) begin
            ev[r+1] = 1; ed[r+1] = clip; eo[r+1] = ov;
          end else begin
            win_sum += clip; win_n++;
            win_ovf = win_ovf | (ov != 0);
            if (win_n == 4) begin
              ev[r+1] = 1; ed[r+1] = win_sum / 4; eo[r+1] = int'(win_ovf);
              win_sum = 0; win_n = 0; win_ovf = 1'b0;
            end
          end
        end
      end
      mode_prev = md[r];
    end

    for (int c = 0; c < n; c++) begin
      @(posedge clk_i);
      #1;
      if (ev[c] != 0) begin hold_d = ed[c]; hold_o = eo[c]; end
      check($sformatf("%s c%0d valid", tag, c), 32'(d_valid_o), 32'(ev[c]));
      check($sformatf("%s c%0d d_o", tag, c), 32'(d_o), 32'(hold_d));
      check($sformatf("%s c%0d ovf", tag, c), 32'(ovf_o), 32'(hold_o));
      sample_valid_i = 1'b0;
      d_stage_i      = 4'($urandom);
      d_last_stage_i = 1'($urandom);
      mode_i         = md[c];
      for (int i = 0; i < ns; i++) begin
        if (s_t[i] == c) begin
          sample_valid_i = 1'b1;
          d_stage_i[1:0] = 2'(s_a[i]);
        end
        if (s_t[i] + 1 == c) d_stage_i[3:2] = 2'(s_b[i]);
        if (s_t[i] + 2 == c) d_last_stage_i = 1'(s_l[i]);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; mode_i = 1'b0; sample_valid_i = 1'b0;
    d_stage_i = '0; d_last_stage_i = '0;
    reset_model();
    #12;
    check("reset d_o", 32'(d_o), 0);
    check("reset valid", 32'(d_valid_o), 0);
    check("reset ovf", 32'(ovf_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Single raw sample: 2*2+2+1 = 7.
    new_phase(1'b0);
    add(2, 2, 2, 1);
    run_phase("raw1", 10);

    // Overflow clamp (9 -> 7) followed by an in-range sample (3).
    new_phase(1'b0);
    add(1, 3, 2, 1);
    add(5, 1, 1, 0);
    run_phase("rawovf", 12);

    // Streaming with gaps, random codes.
    new_phase(1'b0);
    add_rand(0); add_rand(1); add_rand(2); add_rand(3);
    add_rand(5); add_rand(6); add_rand(9); add_rand(10);
    run_phase("stream", 16);

    // Average: 7,6,5,3 -> 5; then a window containing a clamped sample.
    new_phase(1'b1);
    add(0, 2, 2, 1); add(1, 2, 1, 1); add(2, 2, 1, 0); add(3, 1, 1, 0);
    add(8, 3, 2, 1); add_rand(9); add_rand(11); add_rand(12);
    run_phase("avg", 20);

    // Two averaged results, toggle to raw (discarding them), back to avg on a
    // cycle that carries a result, then a full window.
    new_phase(1'b1);
    for (int c = 4; c < 8; c++) md[c] = 1'b0;
    add_rand(0); add_rand(1); add_rand(3); add_rand(5);
    add_rand(6); add_rand(7); add_rand(8); add_rand(9);
    run_phase("toggle", 16);

    // Random schedule with random mode changes.
    new_phase(1'b0);
    for (int c = 0; c < 40; c += 3) begin
      logic m;
      m = 1'($urandom);
      for (int j = c; j < c + 3 && j < MAXC; j++) md[j] = m;
    end
    for (int t = 0; t < 34; t++) if ($urandom_range(2, 0) != 0) add_rand(t);
    run_phase("random", 40);

    // Leave a clamped raw word on the output before the reset test.
    new_phase(1'b0);
    add(0, 3, 3, 1);
    run_phase("prerst", 6);

    // Async reset with two samples in flight.
    @(posedge clk_i); #1;
    mode_i = 1'b0; sample_valid_i = 1'b1;
    d_stage_i = 4'b0010; d_last_stage_i = 1'b0;
    @(posedge clk_i); #1;
    sample_valid_i = 1'b1;
    d_stage_i = 4'b1111; d_last_stage_i = 1'b1;
    check("prerst hold d_o", 32'(d_o), 7);
    #3;
    reset_i = 1'b1;
    #1;
    check("async rst d_o", 32'(d_o), 0);
    check("async rst valid", 32'(d_valid_o), 0);
    check("async rst ovf", 32'(ovf_o), 0);
    sample_valid_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    reset_model();

    // No strobe from lost samples; next sample 2*1+2+0 = 4.
    new_phase(1'b0);
    add(2, 1, 2, 0);
    run_phase("postrst", 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
